// File: rtl/mix_columns_seq.sv
// AES MixColumns stage, one column per cycle through a shared datapath.
// Final-round blocks bypass the mix and are presented on the next cycle.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         last_round,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } st_t;

  st_t          st;
  st_t          nst;
  logic [1:0]   col;
  logic [127:0] sreg;
  logic [127:0] res;
  logic [31:0]  a;
  logic [31:0]  r;
  logic         accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [7:0] b);
    return xt(b) ^ b;
  endfunction

  assign in_ready  = (st == IDLE) || ((st == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (st == DONE);
  assign out       = res;

  always_comb begin
    a = sreg[127:96];
    unique case (col)
      2'd0: a = sreg[127:96];
      2'd1: a = sreg[95:64];
      2'd2: a = sreg[63:32];
      2'd3: a = sreg[31:0];
    endcase
  end

  // a[31:24] is row 0 of the selected column
  always_comb begin
    r[31:24] = xt(a[31:24]) ^ x3(a[23:16]) ^ a[15:8] ^ a[7:0];
    r[23:16] = a[31:24] ^ xt(a[23:16]) ^ x3(a[15:8]) ^ a[7:0];
    r[15:8]  = a[31:24] ^ a[23:16] ^ xt(a[15:8]) ^ x3(a[7:0]);
    r[7:0]   = x3(a[31:24]) ^ a[23:16] ^ a[15:8] ^ xt(a[7:0]);
  end

  always_comb begin
    nst = st;
    case (st)
      IDLE: if (in_valid) nst = last_round ? DONE : CALC;
      CALC: if (col == 2'd3) nst = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) nst = last_round ? DONE : CALC;
          else          nst = IDLE;
        end
      end
      default: nst = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      col  <= 2'd0;
      sreg <= '0;
      res  <= '0;
    end else begin
      st <= nst;
      if (accept) begin
        if (last_round) begin
          res <= in;
        end else begin
          sreg <= in;
          col  <= 2'd0;
        end
      end else if (st == CALC) begin
        col <= col + 2'd1;
        unique case (col)
          2'd0: res[127:96] <= r;
          2'd1: res[95:64]  <= r;
          2'd2: res[63:32]  <= r;
          2'd3: res[31:0]   <= r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: latency, bypass, backpressure,
// back-to-back streaming and mid-operation reset.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic [127:0] in;
  logic         in_valid;
  logic         in_ready;
  logic         last_round;
  logic [127:0] out;
  logic         out_valid;
  logic         out_ready;

  int checks;
  int failures;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V3 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] V4 = 128'h01010101_c6c6c6c6_db135345_f20a225c;
  localparam logic [127:0] E4 = 128'h01010101_c6c6c6c6_8e4da1bc_9fdc589d;

  mix_columns_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .last_round (last_round),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!out_valid && n < max) begin
      step();
      n++;
    end
  endtask

  logic [127:0] blk [3];
  logic [127:0] exb [3];
  int n;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in = '0;
    in_valid = 1'b0;
    last_round = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out", out, '0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd1);
    step();
    step();
    rst = 1'b0;

    // normal round
    in = V1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(10, n);
    chk("norm_lat", 128'(n), 128'd4);
    chk("norm_out", out, E1);
    step();
    chk("idle_valid", 128'(out_valid), 128'd0);
    chk("idle_hold", out, E1);

    // second normal round
    in = V2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(10, n);
    chk("norm2_lat", 128'(n), 128'd4);
    chk("norm2_out", out, E2);
    step();

    // bypass
    in = V3;
    last_round = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("byp_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    last_round = 1'b0;
    chk("byp_valid", 128'(out_valid), 128'd1);
    chk("byp_out", out, V3);
    step();

    // backpressure with a bypass block waiting
    in = V1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(10, n);
    chk("bp_lat", 128'(n), 128'd4);
    out_ready = 1'b0;
    in = V3;
    last_round = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_ready", 128'(in_ready), 128'd0);
      chk("bp_out", out, E1);
      chk("bp_valid", 128'(out_valid), 128'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    last_round = 1'b0;
    chk("bp_second", out, V3);
    chk("bp_second_v", 128'(out_valid), 128'd1);
    step();

    // back-to-back stream
    blk[0] = V1; exb[0] = E1;
    blk[1] = V2; exb[1] = E2;
    blk[2] = V4; exb[2] = E4;
    in = blk[0];
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("b2b_calc_ready", 128'(in_ready), 128'd0);
      wait_valid(10, n);
      chk("b2b_lat", 128'(n), 128'd4);
      chk("b2b_out", out, exb[k]);
      chk("b2b_model", out, model(blk[k]));
      if (k < 2) begin
        in = blk[k+1];
        #1;
        chk("b2b_ready", 128'(in_ready), 128'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    step();

    // reset in the middle of a CALC
    in = V2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_out", out, '0);
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd1);
    step();
    rst = 1'b0;
    in = V1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(10, n);
    chk("post_rst_lat", 128'(n), 128'd4);
    chk("post_rst_out", out, E1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
